alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   Registered WIDTH-bit arithmetic/logic unit with eight operations selected by op.
//   Outputs are the result y, a carry/borrow/shift-out flag and a zero flag.
//   Inputs are sampled on each rising clk edge, and outputs update on that edge.
//   Used as the datapath execute stage; it is freely pipelined and has no handshake.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (WIDTH >= 2)
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst    in   1      reset, synchronous, active-high
//   a      in   WIDTH  operand A (the sole operand for NOT/SHL/SHR)
//   b      in   WIDTH  operand B (ignored for NOT/SHL/SHR)
//   op     in   3      operation select
//   y      out  WIDTH  registered result
//   carry  out  1      registered carry/borrow/shift-out flag
//   zero   out  1      registered flag, 1 when y == 0
// BEHAVIOUR
//   - Reset: the clock edge with rst=1 sets y=0, carry=0, zero=1.
//     - Reset overrides any operation in flight and has no effect between edges.
//   - Latency: exactly 1 cycle. Values of a, b, op at edge N appear on y/carry/zero after edge N.
//     - Outputs hold between edges; a new op issues every cycle.
//   - op encoding (arithmetic is unsigned, modulo 2^WIDTH):
//     - 000 ADD: y = a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum.
//     - 001 SUB: y = a-b; carry = borrow, i.e. 1 iff a < b (unsigned).
//     - 010 AND: y = a & b; carry = 0.
//     - 011 OR:  y = a | b; carry = 0.
//     - 100 XOR: y = a ^ b; carry = 0.
//     - 101 NOT: y = ~a; carry = 0.
//     - 110 SHL: y = {a[WIDTH-2:0],1'b0}; carry = a[WIDTH-1].
//     - 111 SHR: y = {1'b0,a[WIDTH-1:1]} (logical shift); carry = a[0].
//   - zero = (next y == 0) for every op. The invariant zero == (y == 0) always holds, including after reset.
//   - Wrap-around: 0xFF+0x01 gives y=0x00, carry=1, zero=1. 0x00-0x01 gives y=0xFF, carry=1.
//   - X/unknown op values are not supported.
//     - Every 3-bit code is defined, so no default or illegal state exists.
// TESTING (WIDTH=8, each row is one cycle, check outputs after the edge)
//   1. rst=1 for 2 edges -> y=0x00 carry=0 zero=1; release rst, outputs follow next op.
//   2. ADD a=10 b=5 -> y=15 c=0 z=0.
//      SUB a=10 b=3 -> y=7 c=0 z=0.
//      SUB a=5 b=5 -> y=0 c=0 z=1.
//   3. a=0xAA b=0xCC: AND -> 0x88, OR -> 0xEE, XOR -> 0x66; c=0 z=0 for all three.
//   4. NOT a=0x0F -> y=0xF0 c=0.
//      SHL a=0x03 -> y=0x06 c=0.
//      SHR a=0x03 -> y=0x01 c=1.
//      SHL a=0x80 -> y=0x00 c=1 z=1.
//   5. Wrap: ADD 0xFF+0x01 -> y=0x00 c=1 z=1. SUB 0x00-0x01 -> y=0xFF c=1 z=0.
//   6. Back-to-back op change every cycle with rst asserted mid-stream.
//      - Result lags the inputs by exactly 1 edge.
//      - The rst edge forces the reset values regardless of op.

Source files
------------

// File: rtl/alu.sv
// Registered WIDTH-bit ALU: eight ops selected by op, one-cycle latency.
// Outputs y, carry (carry/borrow/shift-out) and zero (y == 0) update on each rising edge.
module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] y_d;
    logic             carry_d;
    logic             zero_d;

    // Widened by one bit so the top bit is the carry-out or the borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y_d     = '0;
        carry_d = 1'b0;
        unique case (op)
            OpAdd: begin
                y_d     = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OpSub: begin
                y_d     = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
            end
            OpAnd: y_d = a & b;
            OpOr:  y_d = a | b;
            OpXor: y_d = a ^ b;
            OpNot: y_d = ~a;
            OpShl: begin
                y_d     = {a[WIDTH-2:0], 1'b0};
                carry_d = a[WIDTH-1];
            end
            OpShr: begin
                y_d     = {1'b0, a[WIDTH-1:1]};
                carry_d = a[0];
            end
            default: begin
                y_d     = '0;
                carry_d = 1'b0;
            end
        endcase
        zero_d = (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
        end else begin
            y     <= y_d;
            carry <= carry_d;
            zero  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (WIDTH=8): each vector is one clock edge,
// checked just after the edge; outputs are also checked to hold before the edge.
module tb_alu;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic [7:0] y;
    logic       carry;
    logic       zero;

    int checks = 0;
    int errors = 0;

    logic       have_prev = 1'b0;
    logic [7:0] prev_y;
    logic       prev_c;
    logic       prev_z;

    alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .y     (y),
        .carry (carry),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one vector, confirm outputs hold until the edge, then check the new result.
    task automatic apply(input string tag, input logic r, input logic [2:0] o,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] ey, input logic ec, input logic ez);
        rst = r;
        op  = o;
        a   = va;
        b   = vb;
        #2;
        if (have_prev) begin
            check({tag, " hold y"}, {24'd0, y}, {24'd0, prev_y});
            check({tag, " hold c"}, {31'd0, carry}, {31'd0, prev_c});
            check({tag, " hold z"}, {31'd0, zero}, {31'd0, prev_z});
        end
        @(posedge clk);
        #1;
        check({tag, " y"}, {24'd0, y}, {24'd0, ey});
        check({tag, " c"}, {31'd0, carry}, {31'd0, ec});
        check({tag, " z"}, {31'd0, zero}, {31'd0, ez});
        prev_y    = ey;
        prev_c    = ec;
        prev_z    = ez;
        have_prev = 1'b1;
    endtask

    initial begin
        // 1. reset for two edges
        apply("rst0", 1'b1, OpAdd, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
        apply("rst1", 1'b1, OpShl, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1);

        // 2. add / sub
        apply("add10_5", 1'b0, OpAdd, 8'd10, 8'd5, 8'd15, 1'b0, 1'b0);
        apply("sub10_3", 1'b0, OpSub, 8'd10, 8'd3, 8'd7, 1'b0, 1'b0);
        apply("sub5_5",  1'b0, OpSub, 8'd5, 8'd5, 8'd0, 1'b0, 1'b1);

        // 3. logic
        apply("and", 1'b0, OpAnd, 8'hAA, 8'hCC, 8'h88, 1'b0, 1'b0);
        apply("or",  1'b0, OpOr,  8'hAA, 8'hCC, 8'hEE, 1'b0, 1'b0);
        apply("xor", 1'b0, OpXor, 8'hAA, 8'hCC, 8'h66, 1'b0, 1'b0);

        // 4. not / shifts (b is ignored, so drive junk on it)
        apply("not0f",  1'b0, OpNot, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0);
        apply("shl03",  1'b0, OpShl, 8'h03, 8'hFF, 8'h06, 1'b0, 1'b0);
        apply("shr03",  1'b0, OpShr, 8'h03, 8'hFF, 8'h01, 1'b1, 1'b0);
        apply("shl80",  1'b0, OpShl, 8'h80, 8'h01, 8'h00, 1'b1, 1'b1);
        apply("shr80",  1'b0, OpShr, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0);
        apply("notff",  1'b0, OpNot, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);

        // 5. wrap-around
        apply("addwrap", 1'b0, OpAdd, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        apply("subwrap", 1'b0, OpSub, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        apply("addc_nz", 1'b0, OpAdd, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);

        // 6. back-to-back with reset mid-stream
        apply("b2b_add",  1'b0, OpAdd, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
        apply("b2b_sub",  1'b0, OpSub, 8'd3, 8'd4, 8'hFF, 1'b1, 1'b0);
        apply("b2b_rst",  1'b1, OpAdd, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
        apply("b2b_xor",  1'b0, OpXor, 8'h5A, 8'h0F, 8'h55, 1'b0, 1'b0);
        apply("b2b_rst2", 1'b1, OpShr, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
        apply("b2b_shr",  1'b0, OpShr, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
        apply("b2b_or",   1'b0, OpOr,  8'h81, 8'h18, 8'h99, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
